// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED Hamming codec with error injection, valid/ready flow and
// saturating error statistics. Stage 1 encodes and injects; stage 2 decodes,
// corrects and classifies the word.
module hamming_secded_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PAR_W   = 6,
  parameter int unsigned CODE_W  = DATA_W + PAR_W + 1,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data,
  input  logic [1:0]         inject_mode,
  input  logic [5:0]         inject_pos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  dec_data,
  output logic               single_err,
  output logic               double_err,
  output logic [5:0]         err_pos,
  output logic [COUNT_W-1:0] corr_cnt,
  output logic [COUNT_W-1:0] unc_cnt,
  input  logic               cnt_clear
);

  localparam int LAST_POS = int'(CODE_W) - 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // XOR of the positions of all set bits in 1..CODE_W-1
  function automatic logic [PAR_W-1:0] syndrome_of(input logic [CODE_W-1:0] c);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int i = 1; i < int'(CODE_W); i++)
      if (c[i]) s = s ^ PAR_W'(i);
    return s;
  endfunction

  // Data at non-power-of-two positions, parity at powers of two, bit 0 overall parity
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic [PAR_W-1:0]  s;
    int                j;
    c = '0;
    j = 0;
    for (int i = 1; i < int'(CODE_W); i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    s = syndrome_of(c);
    for (int i = 1; i < int'(CODE_W); i++)
      if ((i & (i - 1)) == 0) c[i] = |(s & PAR_W'(i));
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  // Gather data bits back from the non-power-of-two positions
  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int i = 1; i < int'(CODE_W); i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  logic              advance;
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [CODE_W-1:0] inj_mask;
  logic [CODE_W-1:0] enc_code;
  logic [PAR_W-1:0]  syn;
  logic              par;
  logic              fix;
  logic              dbl;
  logic [CODE_W-1:0] corr_code;
  int                pos_i;
  int                nxt_i;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign enc_code = encode(data);

  // Injection mask: one or two adjacent (wrapping) positions, none when out of range
  always_comb begin
    inj_mask = '0;
    pos_i    = int'(inject_pos);
    nxt_i    = (pos_i == LAST_POS) ? 0 : pos_i + 1;
    for (int i = 0; i < int'(CODE_W); i++) begin
      if (pos_i <= LAST_POS) begin
        if ((inject_mode == 2'b01 || inject_mode == 2'b10) && i == pos_i) inj_mask[i] = 1'b1;
        if (inject_mode == 2'b10 && i == nxt_i) inj_mask[i] = 1'b1;
      end
    end
  end

  // Syndrome classification and single-bit correction of the stage-1 word
  always_comb begin
    syn       = syndrome_of(s1_code);
    par       = ^s1_code;
    fix       = par && (int'(syn) <= LAST_POS);
    dbl       = (!par && syn != '0) || (par && int'(syn) > LAST_POS);
    corr_code = s1_code;
    for (int i = 0; i < int'(CODE_W); i++)
      if (fix && int'(syn) == i) corr_code[i] = ~s1_code[i];
  end

  // Both pipeline stages move together whenever the output slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_code    <= '0;
      out_valid  <= 1'b0;
      dec_data   <= '0;
      single_err <= 1'b0;
      double_err <= 1'b0;
      err_pos    <= '0;
    end else if (advance) begin
      s1_valid   <= in_valid;
      s1_code    <= in_valid ? (enc_code ^ inj_mask) : '0;
      out_valid  <= s1_valid;
      dec_data   <= s1_valid ? extract(corr_code) : '0;
      single_err <= s1_valid && fix;
      double_err <= s1_valid && dbl;
      err_pos    <= (s1_valid && fix) ? 6'(syn) : 6'd0;
    end
  end

  // Saturating statistics on delivered words; clear beats increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      corr_cnt <= '0;
      unc_cnt  <= '0;
    end else if (out_valid && out_ready) begin
      if (single_err && corr_cnt != CNT_MAX) corr_cnt <= corr_cnt + COUNT_W'(1);
      if (double_err && unc_cnt != CNT_MAX) unc_cnt <= unc_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed and randomized checks of hamming_secded_pipe against a behavioural
// model: an injected single flip is always corrected, two distinct flips are
// always flagged and leave the data bits as injected.
module tb_hamming_secded_pipe;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PAR_W   = 6;
  localparam int unsigned CODE_W  = 39;
  localparam int unsigned COUNT_W = 2;
  localparam int          CMAX    = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  data;
  logic [1:0]         inject_mode;
  logic [5:0]         inject_pos;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  dec_data;
  logic               single_err;
  logic               double_err;
  logic [5:0]         err_pos;
  logic [COUNT_W-1:0] corr_cnt;
  logic [COUNT_W-1:0] unc_cnt;
  logic               cnt_clear;

  always #5 clk = ~clk;

  hamming_secded_pipe #(
    .DATA_W(DATA_W), .PAR_W(PAR_W), .CODE_W(CODE_W), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .inject_mode(inject_mode), .inject_pos(inject_pos),
    .out_valid(out_valid), .out_ready(out_ready), .dec_data(dec_data),
    .single_err(single_err), .double_err(double_err), .err_pos(err_pos),
    .corr_cnt(corr_cnt), .unc_cnt(unc_cnt), .cnt_clear(cnt_clear)
  );

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        db;
    logic [5:0]  ep;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;
  int   corr_m = 0;
  int   unc_m  = 0;
  int   deliv  = 0;
  bit   acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Data index of a codeword position, -1 for parity positions
  function automatic int data_idx(input int p);
    if (p < 3) return -1;
    if ((p & (p - 1)) == 0) return -1;
    return p - $clog2(p + 1) - 1;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] d, input logic [1:0] m, input logic [5:0] p);
    exp_t e;
    int   a, b, k;
    e.d = d; e.s = 1'b0; e.db = 1'b0; e.ep = 6'd0;
    a = int'(p);
    if (a >= int'(CODE_W)) return e;
    if (m == 2'b01) begin
      e.s  = 1'b1;
      e.ep = p;
    end else if (m == 2'b10) begin
      e.db = 1'b1;
      b = (a + 1) % int'(CODE_W);
      k = data_idx(a);
      if (k >= 0) e.d[k] = ~e.d[k];
      k = data_idx(b);
      if (k >= 0) e.d[k] = ~e.d[k];
    end
    return e;
  endfunction

  // One clock: score deliveries, record acceptances, update counter model
  task automatic cycle(output bit accepted);
    exp_t e;
    bit   del;
    @(negedge clk);
    accepted = in_valid && in_ready;
    del      = out_valid && out_ready;
    e = '{d: 32'd0, s: 1'b0, db: 1'b0, ep: 6'd0};
    if (!out_valid) begin
      chk("idle_data", 64'(dec_data), 64'(0));
      chk("idle_flags", 64'({single_err, double_err, err_pos}), 64'(0));
    end
    if (del) begin
      if (q.size() == 0) chk("spurious_out", 64'(1), 64'(0));
      else begin
        e = q.pop_front();
        deliv++;
        chk("dec_data", 64'(dec_data), 64'(e.d));
        chk("single_err", 64'(single_err), 64'(e.s));
        chk("double_err", 64'(double_err), 64'(e.db));
        chk("err_pos", 64'(err_pos), 64'(e.ep));
      end
    end
    if (accepted) q.push_back(ref_model(data, inject_mode, inject_pos));
    if (cnt_clear) begin
      corr_m = 0;
      unc_m  = 0;
    end else if (del) begin
      if (e.s && corr_m < CMAX) corr_m++;
      if (e.db && unc_m < CMAX) unc_m++;
    end
    @(posedge clk);
    #1;
    chk("corr_cnt", 64'(corr_cnt), 64'(corr_m));
    chk("unc_cnt", 64'(unc_cnt), 64'(unc_m));
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [5:0] p);
    bit a;
    a = 1'b0;
    in_valid = 1'b1; data = d; inject_mode = m; inject_pos = p;
    for (int n = 0; n < 20 && !a; n++) cycle(a);
    if (!a) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) cycle(a);
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cnt_clear = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    corr_m = 0;
    unc_m  = 0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dec_data", 64'(dec_data), 64'(0));
    chk("rst_flags", 64'({single_err, double_err, err_pos}), 64'(0));
    chk("rst_corr_cnt", 64'(corr_cnt), 64'(0));
    chk("rst_unc_cnt", 64'(unc_cnt), 64'(0));
    #1;
    chk("rst_release_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int   idx, stall, d0;
    bit   seen;
    rst = 1'b1; in_valid = 1'b0; data = '0; inject_mode = 2'b00; inject_pos = 6'd0;
    out_ready = 1'b1; cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Clean word and two-edge latency
    in_valid = 1'b1; data = 32'd4; inject_mode = 2'b00; inject_pos = 6'd0;
    cycle(acc);
    in_valid = 1'b0;
    chk("t1_accept", 64'(acc), 64'(1));
    chk("t1_lat_edge1", 64'(out_valid), 64'(0));
    cycle(acc);
    chk("t1_lat_edge2", 64'(out_valid), 64'(1));
    chk("t1_data", 64'(dec_data), 64'(4));
    chk("t1_flags", 64'({single_err, double_err}), 64'(0));
    drain();

    // Single error at position 3
    chk("t2_cnt_before", 64'(corr_cnt), 64'(0));
    send(32'd8456, 2'b01, 6'd3);
    drain();
    chk("t2_cnt_after", 64'(corr_cnt), 64'(1));

    // Double errors, including the wrap from 38 to 0
    send(32'hDEADBEEF, 2'b10, 6'd5);
    send(32'hDEADBEEF, 2'b10, 6'd38);
    drain();
    chk("t3_unc_cnt", 64'(unc_cnt), 64'(2));

    // Overall parity bit flip and out-of-range position
    send(32'h1234_5678, 2'b01, 6'd0);
    send(32'h1234_5678, 2'b01, 6'd40);
    send(32'h0BAD_F00D, 2'b10, 6'd40);
    drain();

    // Back-to-back stream with a 3-cycle output stall
    idx = 0; stall = 0; seen = 1'b0; d0 = deliv;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 4 || q.size() != 0); c++) begin
      in_valid = (idx < 4); data = 32'(idx + 1); inject_mode = 2'b00; inject_pos = 6'd0;
      if (out_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        #1;
        chk("t5_stall_in_ready", 64'(in_ready), 64'(0));
        chk("t5_stall_valid", 64'(out_valid), 64'(1));
        if (q.size() != 0) chk("t5_stall_hold", 64'(dec_data), 64'(q[0].d));
        stall--;
      end else out_ready = 1'b1;
      cycle(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t5_all_accepted", 64'(idx), 64'(4));
    chk("t5_delivered", 64'(deliv - d0), 64'(4));
    chk("t5_q_empty", 64'(q.size()), 64'(0));

    // Counter saturation, clear priority, reset mid-stream
    do_reset();
    for (int n = 0; n < 5; n++) send($urandom, 2'b01, 6'($urandom_range(0, 38)));
    drain();
    chk("t6_saturate", 64'(corr_cnt), 64'(3));
    send(32'hA5A5_0F0F, 2'b01, 6'd7);
    for (int n = 0; n < 10 && !out_valid; n++) cycle(acc);
    chk("t6_clr_single", 64'(single_err), 64'(1));
    cnt_clear = 1'b1; out_ready = 1'b1;
    cycle(acc);
    cnt_clear = 1'b0;
    chk("t6_clear_wins", 64'(corr_cnt), 64'(0));
    in_valid = 1'b1; inject_mode = 2'b01; inject_pos = 6'd12;
    for (int n = 0; n < 3; n++) begin
      data = $urandom;
      cycle(acc);
    end
    chk("t6_pre_rst_valid", 64'(out_valid), 64'(1));
    do_reset();

    // Randomized traffic with random backpressure and occasional clears
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      data        = $urandom;
      inject_mode = 2'($urandom_range(0, 3));
      inject_pos  = 6'($urandom_range(0, 45));
      out_ready   = ($urandom_range(0, 3) != 0);
      cnt_clear   = ($urandom_range(0, 15) == 0);
      cycle(acc);
    end
    cnt_clear = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
